andg_response_checker: RTL

- Synthesizable receive-side counterpart to the AND-gate stimulus driver. It captures each applied (x,y) vector and waits a programmable settle time. It then samples the gate output z and compares it against x&y.
- Accumulates pass/fail counts and truth-table coverage across a session, and reports a final verdict.
- Sits beside the AND-gate DUT in self-checking benches and on-chip BIST wrappers.

---
 rtl/andg_response_checker.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/andg_response_checker.sv
// andg_response_checker: receive-side checker for an AND-gate DUT.
// Captures each applied (x,y) vector and waits SETTLE_CYCLES. It then samples
// z against x&y and accumulates saturating pass/fail counts and truth-table
// coverage. At session end it issues a done pulse with a held pass verdict.
module andg_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  input  logic             session_end,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       coverage,
  output logic             err_pulse,
  output logic [1:0]       err_vec,
  output logic             done,
  output logic             pass
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t             state_r, state_next_s;
  logic [7:0]         settle_cnt_r, settle_cnt_next_s;
  logic               cap_x_r, cap_x_next_s;
  logic               cap_y_r, cap_y_next_s;
  logic               pend_end_r, pend_end_next_s;
  logic [CNT_W-1:0]   pass_cnt_r, pass_cnt_next_s;
  logic [CNT_W-1:0]   fail_cnt_r, fail_cnt_next_s;
  logic [3:0]         coverage_r, coverage_next_s;
  logic               err_pulse_r, err_pulse_next_s;
  logic [1:0]         err_vec_r, err_vec_next_s;
  logic               done_r, done_next_s;
  logic               pass_r, pass_next_s;
  logic               busy_r, busy_next_s;
  logic               match_s;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Session verdict: no failures, all four combinations seen, at least one pass.
  function automatic logic verdict(input logic [CNT_W-1:0] pc,
                                   input logic [CNT_W-1:0] fc,
                                   input logic [3:0]       cov);
    return (fc == '0) && (cov == 4'b1111) && (pc != '0);
  endfunction

  assign match_s = (z == (cap_x_r & cap_y_r));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; a re-applied vector in SETTLE restarts the wait.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   state_next_s = start ? ST_ARMED : ST_IDLE;
      ST_ARMED: begin
        if (vec_valid)        state_next_s = ST_SETTLE;
        else if (session_end) state_next_s = ST_REPORT;
        else                  state_next_s = ST_ARMED;
      end
      ST_SETTLE: begin
        if (vec_valid)                  state_next_s = ST_SETTLE;
        else if (settle_cnt_r == 8'd0)  state_next_s = ST_CHECK;
        else                            state_next_s = ST_SETTLE;
      end
      ST_CHECK: begin
        if (pend_end_r || session_end) state_next_s = ST_REPORT;
        else if (vec_valid)            state_next_s = ST_SETTLE;
        else                           state_next_s = ST_ARMED;
      end
      ST_REPORT: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Next values of datapath and outputs; verdict uses post-CHECK counts.
  always_comb begin
    settle_cnt_next_s = settle_cnt_r;
    cap_x_next_s      = cap_x_r;
    cap_y_next_s      = cap_y_r;
    pend_end_next_s   = pend_end_r;
    pass_cnt_next_s   = pass_cnt_r;
    fail_cnt_next_s   = fail_cnt_r;
    coverage_next_s   = coverage_r;
    err_pulse_next_s  = 1'b0;
    err_vec_next_s    = err_vec_r;
    pass_next_s       = pass_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          pass_cnt_next_s = '0;
          fail_cnt_next_s = '0;
          coverage_next_s = 4'b0000;
          pass_next_s     = 1'b0;
          pend_end_next_s = 1'b0;
        end else begin
          pend_end_next_s = 1'b0;
        end
      end
      ST_ARMED: begin
        if (vec_valid) begin
          cap_x_next_s      = x;
          cap_y_next_s      = y;
          settle_cnt_next_s = SETTLE_LOAD;
          pend_end_next_s   = session_end;
        end else begin
          pend_end_next_s   = pend_end_r;
        end
      end
      ST_SETTLE: begin
        if (vec_valid) begin
          cap_x_next_s      = x;
          cap_y_next_s      = y;
          settle_cnt_next_s = SETTLE_LOAD;
        end else if (settle_cnt_r != 8'd0) begin
          settle_cnt_next_s = settle_cnt_r - 8'd1;
        end else begin
          settle_cnt_next_s = settle_cnt_r;
        end
        if (session_end) pend_end_next_s = 1'b1;
        else             pend_end_next_s = pend_end_r;
      end
      ST_CHECK: begin
        if (match_s) begin
          pass_cnt_next_s = sat_inc(pass_cnt_r);
        end else begin
          fail_cnt_next_s  = sat_inc(fail_cnt_r);
          err_pulse_next_s = 1'b1;
          err_vec_next_s   = {cap_x_r, cap_y_r};
        end
        coverage_next_s[{cap_x_r, cap_y_r}] = 1'b1;
        if (!(pend_end_r || session_end) && vec_valid) begin
          cap_x_next_s      = x;
          cap_y_next_s      = y;
          settle_cnt_next_s = SETTLE_LOAD;
        end else begin
          settle_cnt_next_s = settle_cnt_r;
        end
      end
      ST_REPORT: pend_end_next_s = 1'b0;
      default:   pend_end_next_s = 1'b0;
    endcase
    done_next_s = (state_next_s == ST_REPORT);
    busy_next_s = (state_next_s != ST_IDLE);
    if (done_next_s) begin
      pass_next_s = verdict(pass_cnt_next_s, fail_cnt_next_s, coverage_next_s);
    end else begin
      pass_next_s = pass_next_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_r <= 8'd0;
      cap_x_r      <= 1'b0;
      cap_y_r      <= 1'b0;
      pend_end_r   <= 1'b0;
      pass_cnt_r   <= '0;
      fail_cnt_r   <= '0;
      coverage_r   <= 4'b0000;
      err_pulse_r  <= 1'b0;
      err_vec_r    <= 2'b00;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      settle_cnt_r <= settle_cnt_next_s;
      cap_x_r      <= cap_x_next_s;
      cap_y_r      <= cap_y_next_s;
      pend_end_r   <= pend_end_next_s;
      pass_cnt_r   <= pass_cnt_next_s;
      fail_cnt_r   <= fail_cnt_next_s;
      coverage_r   <= coverage_next_s;
      err_pulse_r  <= err_pulse_next_s;
      err_vec_r    <= err_vec_next_s;
      done_r       <= done_next_s;
      pass_r       <= pass_next_s;
      busy_r       <= busy_next_s;
    end
  end

  assign busy      = busy_r;
  assign pass_cnt  = pass_cnt_r;
  assign fail_cnt  = fail_cnt_r;
  assign coverage  = coverage_r;
  assign err_pulse = err_pulse_r;
  assign err_vec   = err_vec_r;
  assign done      = done_r;
  assign pass      = pass_r;

endmodule
